// File: rtl/gpio_ctrl_apb_master_if.sv
// Bundle of the command, response and APB signals of gpio_ctrl_apb_master.
//   master modport : view of the APB initiator (drives req_ready, rsp_*, APB
//                    request signals; receives req_*, rsp_ready, APB replies)
//   slave modport  : view of whatever sits on the other side (command source,
//                    response sink and APB target)
interface gpio_ctrl_apb_master_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  // Command channel
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [3:0]            req_strb;

  // Response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  // APB
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [3:0]            pstrb;
  logic [31:0]           pwdata;
  logic [31:0]           prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output paddr, pwrite, psel, penable, pstrb, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  paddr, pwrite, psel, penable, pstrb, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/gpio_ctrl_apb_master.sv
// APB initiator: converts a valid/ready command stream into single APB
// transfers (one in flight) and returns read data / error / timeout on a
// valid/ready response channel.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : gpio_ctrl_apb_master_if.master
//            req_valid/req_ready/req_write/req_addr/req_wdata/req_strb
//            rsp_valid/rsp_ready/rsp_rdata/rsp_err/rsp_timeout
//            paddr/pwrite/psel/penable/pstrb/pwdata/prdata/pready/pslverr
// All outputs are registered.
module gpio_ctrl_apb_master #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  gpio_ctrl_apb_master_if.master   bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic                  req_ready_q,   req_ready_d;
  logic                  rsp_valid_q,   rsp_valid_d;
  logic [31:0]           rsp_rdata_q,   rsp_rdata_d;
  logic                  rsp_err_q,     rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
  logic                  pwrite_q,      pwrite_d;
  logic                  psel_q,        psel_d;
  logic                  penable_q,     penable_d;
  logic [3:0]            pstrb_q,       pstrb_d;
  logic [31:0]           pwdata_q,      pwdata_d;
  logic [CNT_W-1:0]      wait_cnt_q,    wait_cnt_d;

  logic [CNT_W-1:0]      wait_cnt_inc;
  logic                  timeout_hit;

  // Abort on the ACCESS cycle that would take the wait count to the limit;
  // pready on that same cycle is checked first and wins.
  assign wait_cnt_inc = wait_cnt_q + 1'b1;
  assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (wait_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pstrb_q       <= '0;
      pwdata_q      <= '0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pstrb_q       <= pstrb_d;
      pwdata_q      <= pwdata_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pstrb_d       = pstrb_q;
    pwdata_d      = pwdata_q;
    wait_cnt_d    = wait_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_ready_d = 1'b0;
          if (bus.req_addr[1:0] != 2'b00) begin
            // Misaligned: answer with an error, never touch the APB bus.
            state_d       = RESP;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
          end else begin
            state_d    = SETUP;
            psel_d     = 1'b1;
            penable_d  = 1'b0;
            paddr_d    = bus.req_addr;
            pwrite_d   = bus.req_write;
            pwdata_d   = bus.req_wdata;
            pstrb_d    = bus.req_write ? bus.req_strb : 4'h0;
            wait_cnt_d = '0;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        if (bus.pready) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? 32'h0 : bus.prdata;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else if (TIMEOUT_CYCLES != 0) begin
          wait_cnt_d = wait_cnt_inc;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.pwdata      = pwdata_q;

endmodule

// File: tb/tb_gpio_ctrl_apb_master.sv
module tb_gpio_ctrl_apb_master;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  gpio_ctrl_apb_master_if #(.ADDR_WIDTH(10)) ifa ();
  gpio_ctrl_apb_master_if #(.ADDR_WIDTH(10)) ifb ();

  gpio_ctrl_apb_master #(.ADDR_WIDTH(10), .TIMEOUT_CYCLES(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  gpio_ctrl_apb_master #(.ADDR_WIDTH(10), .TIMEOUT_CYCLES(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_a(input logic w, input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    ifa.req_valid = 1'b1;
    ifa.req_write = w;
    ifa.req_addr  = a;
    ifa.req_wdata = d;
    ifa.req_strb  = s;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    ifa.req_valid = 0; ifa.req_write = 0; ifa.req_addr = '0; ifa.req_wdata = '0; ifa.req_strb = '0;
    ifa.rsp_ready = 1; ifa.prdata = '0; ifa.pready = 1; ifa.pslverr = 0;
    ifb.req_valid = 0; ifb.req_write = 0; ifb.req_addr = '0; ifb.req_wdata = '0; ifb.req_strb = '0;
    ifb.rsp_ready = 1; ifb.prdata = '0; ifb.pready = 0; ifb.pslverr = 0;

    // Reset state
    step(); step();
    chk("rst_req_ready", 32'(ifa.req_ready), 32'd1);
    chk("rst_psel_pen",  32'({ifa.psel, ifa.penable}), 32'd0);
    chk("rst_rsp",       32'({ifa.rsp_valid, ifa.rsp_err, ifa.rsp_timeout}), 32'd0);
    chk("rst_rdata",     ifa.rsp_rdata, 32'h0);
    chk("rst_paddr",     32'(ifa.paddr), 32'h0);
    rst_n = 1'b1;
    step();

    // 1: aligned write, zero-wait slave
    send_a(1'b1, 10'h004, 32'hA5A5_0F0F, 4'hF);           // T
    step();                                                // T+1 SETUP
    ifa.req_valid = 0;
    chk("w_setup_sel",   32'({ifa.psel, ifa.penable}), 32'b10);
    chk("w_setup_paddr", 32'(ifa.paddr), 32'h004);
    chk("w_setup_ctl",   32'({ifa.pwrite, ifa.pstrb}), 32'h1F);
    chk("w_setup_wdata", ifa.pwdata, 32'hA5A5_0F0F);
    chk("w_setup_rdy",   32'(ifa.req_ready), 32'd0);
    step();                                                // T+2 ACCESS
    chk("w_acc_sel",     32'({ifa.psel, ifa.penable}), 32'b11);
    chk("w_acc_paddr",   32'(ifa.paddr), 32'h004);
    chk("w_acc_ctl",     32'({ifa.pwrite, ifa.pstrb}), 32'h1F);
    chk("w_acc_wdata",   ifa.pwdata, 32'hA5A5_0F0F);
    chk("w_acc_rspv",    32'(ifa.rsp_valid), 32'd0);
    step();                                                // T+3 RESP
    chk("w_rsp_flags",   32'({ifa.rsp_valid, ifa.rsp_err, ifa.rsp_timeout}), 32'b100);
    chk("w_rsp_rdata",   ifa.rsp_rdata, 32'h0);
    chk("w_rsp_sel",     32'({ifa.psel, ifa.penable}), 32'b00);
    step();                                                // T+4 IDLE
    chk("w_done_rspv",   32'(ifa.rsp_valid), 32'd0);
    chk("w_done_rdy",    32'(ifa.req_ready), 32'd1);

    // 2: read with two wait states
    send_a(1'b0, 10'h200, 32'hFFFF_FFFF, 4'hF);           // T
    ifa.pready = 0;
    step();                                                // T+1 SETUP
    ifa.req_valid = 0;
    chk("r_setup_sel",   32'({ifa.psel, ifa.penable}), 32'b10);
    chk("r_setup_ctl",   32'({ifa.pwrite, ifa.pstrb}), 32'h00);
    chk("r_setup_paddr", 32'(ifa.paddr), 32'h200);
    step();                                                // T+2
    chk("r_acc1",        32'({ifa.psel, ifa.penable, ifa.pstrb}), 32'b110000);
    step();                                                // T+3
    chk("r_acc2",        32'({ifa.psel, ifa.penable, ifa.pstrb}), 32'b110000);
    step();                                                // T+4
    chk("r_acc3",        32'({ifa.psel, ifa.penable, ifa.pstrb}), 32'b110000);
    chk("r_acc3_rspv",   32'(ifa.rsp_valid), 32'd0);
    ifa.pready = 1; ifa.prdata = 32'h1234_5678;
    step();                                                // T+5 RESP
    chk("r_rsp_flags",   32'({ifa.rsp_valid, ifa.rsp_err, ifa.rsp_timeout}), 32'b100);
    chk("r_rsp_rdata",   ifa.rsp_rdata, 32'h1234_5678);
    chk("r_rsp_sel",     32'({ifa.psel, ifa.penable}), 32'b00);
    step();                                                // T+6 IDLE
    chk("r_done_rspv",   32'(ifa.rsp_valid), 32'd0);

    // 3: write completed with pslverr
    send_a(1'b1, 10'h010, 32'h0000_0001, 4'h1);
    ifa.pslverr = 1;
    step();
    ifa.req_valid = 0;
    step();
    chk("e_acc_sel",     32'({ifa.psel, ifa.penable}), 32'b11);
    step();
    chk("e_rsp_flags",   32'({ifa.rsp_valid, ifa.rsp_err, ifa.rsp_timeout}), 32'b110);
    chk("e_rsp_sel",     32'({ifa.psel, ifa.penable}), 32'b00);
    chk("e_rsp_rdata",   ifa.rsp_rdata, 32'h0);
    ifa.pslverr = 0;
    step();

    // 4: timeout after 16 ACCESS cycles, late pready ignored
    send_a(1'b0, 10'h008, 32'h0, 4'h0);                    // T
    ifa.pready = 0; ifa.prdata = 32'hDEAD_BEEF;
    step();                                                // T+1
    ifa.req_valid = 0;
    chk("t_setup_sel",   32'({ifa.psel, ifa.penable}), 32'b10);
    for (int k = 0; k < 16; k++) begin
      step();                                              // T+2 .. T+17
      chk("t_acc_wait",  32'({ifa.psel, ifa.penable, ifa.rsp_valid}), 32'b110);
    end
    step();                                                // T+18
    chk("t_rsp_flags",   32'({ifa.rsp_valid, ifa.rsp_err, ifa.rsp_timeout}), 32'b111);
    chk("t_rsp_rdata",   ifa.rsp_rdata, 32'h0);
    chk("t_rsp_sel",     32'({ifa.psel, ifa.penable}), 32'b00);
    ifa.pready = 1;
    step();                                                // T+19
    ifa.pready = 0;
    chk("t_late1",       32'({ifa.rsp_valid, ifa.psel}), 32'b00);
    step();
    chk("t_late2",       32'({ifa.rsp_valid, ifa.psel, ifa.req_ready}), 32'b001);
    ifa.pready = 1;

    // 5: misaligned read
    send_a(1'b0, 10'h006, 32'h0, 4'h0);                    // T
    step();                                                // T+1
    ifa.req_valid = 0;
    chk("m_rsp_flags",   32'({ifa.rsp_valid, ifa.rsp_err, ifa.rsp_timeout}), 32'b110);
    chk("m_rsp_rdata",   ifa.rsp_rdata, 32'h0);
    chk("m_psel1",       32'({ifa.psel, ifa.penable}), 32'b00);
    step();
    chk("m_psel2",       32'({ifa.psel, ifa.penable, ifa.rsp_valid}), 32'b000);

    // 6: response backpressure, second request held off
    ifa.rsp_ready = 0; ifa.prdata = 32'hCAFE_0001;
    send_a(1'b1, 10'h020, 32'h1111_2222, 4'h3);           // T
    step();                                                // T+1
    send_a(1'b0, 10'h024, 32'h0, 4'hF);
    chk("b_setup_paddr", 32'(ifa.paddr), 32'h020);
    step();                                                // T+2
    step();                                                // T+3
    for (int i = 0; i < 5; i++) begin                      // T+3 .. T+7
      chk("b_hold_flags", 32'({ifa.rsp_valid, ifa.rsp_err, ifa.rsp_timeout, ifa.req_ready}), 32'b1000);
      chk("b_hold_rdata", ifa.rsp_rdata, 32'h0);
      chk("b_hold_paddr", 32'({ifa.psel, ifa.paddr}), 32'h020);
      if (i == 4) ifa.rsp_ready = 1;
      step();
    end
    chk("b_hs_done",     32'({ifa.rsp_valid, ifa.req_ready}), 32'b01); // T+8
    step();                                                // T+9
    ifa.req_valid = 0;
    chk("b2_setup",      32'({ifa.psel, ifa.penable, ifa.pwrite, ifa.pstrb}), 32'h40);
    chk("b2_paddr",      32'(ifa.paddr), 32'h024);
    step();                                                // T+10
    step();                                                // T+11
    chk("b2_rsp",        ifa.rsp_rdata, 32'hCAFE_0001);
    chk("b2_flags",      32'({ifa.rsp_valid, ifa.rsp_err}), 32'b10);
    step();

    // 7: reset during ACCESS
    send_a(1'b1, 10'h030, 32'h5555_AAAA, 4'hF);
    ifa.pready = 0;
    step();
    ifa.req_valid = 0;
    step();
    chk("x_acc",         32'({ifa.psel, ifa.penable}), 32'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("x_rst_now",     32'({ifa.psel, ifa.penable, ifa.rsp_valid}), 32'b000);
    step();
    rst_n = 1'b1;
    ifa.pready = 1;
    step();
    chk("x_after1",      32'({ifa.req_ready, ifa.psel, ifa.rsp_valid}), 32'b100);
    step();
    chk("x_after2",      32'({ifa.req_ready, ifa.psel, ifa.rsp_valid}), 32'b100);

    // 8: timeout disabled, pready after 100 wait cycles
    ifb.req_valid = 1; ifb.req_write = 0; ifb.req_addr = 10'h040;  // T
    step();                                                // T+1
    ifb.req_valid = 0;
    chk("n_setup",       32'({ifb.psel, ifb.penable}), 32'b10);
    for (int k = 0; k < 100; k++) begin
      step();                                              // T+2 .. T+101
      chk("n_wait",      32'({ifb.psel, ifb.penable, ifb.rsp_valid}), 32'b110);
    end
    step();                                                // T+102
    chk("n_last_wait",   32'({ifb.psel, ifb.penable, ifb.rsp_valid}), 32'b110);
    ifb.pready = 1; ifb.prdata = 32'h0BAD_F00D;
    step();                                                // T+103
    chk("n_rsp_flags",   32'({ifb.rsp_valid, ifb.rsp_err, ifb.rsp_timeout}), 32'b100);
    chk("n_rsp_rdata",   ifb.rsp_rdata, 32'h0BAD_F00D);
    chk("n_rsp_sel",     32'({ifb.psel, ifb.penable}), 32'b00);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl_apb_master.md
Name: gpio_ctrl_apb_master

Overview:
- APB initiator that turns a simple valid/ready command stream into single APB transfers.
- Intended targets: the GPIO controller's APB port (bank CSRs, interrupt status CSR). Used by an on-chip sequencer/debug port, and by the verification environment as a reusable driver.
- One transfer in flight at a time.
- Reports read data, slave error and timeout on a valid/ready response channel.

Parameters:
- ADDR_WIDTH, 10, width of req_addr/paddr.
- TIMEOUT_CYCLES, 16, max ACCESS-phase cycles waiting for pready; 0 disables timeout.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  command valid
- req_ready  output  1  command accepted when valid&ready
- req_write  input  1  1=write, 0=read
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  32  write data
- req_strb  input  4  write byte strobes
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumed when valid&ready
- rsp_rdata  output  32  read data (0 for writes/errors)
- rsp_err  output  1  pslverr, misalignment or timeout
- rsp_timeout  output  1  transfer aborted by timeout
- paddr  output  ADDR_WIDTH  APB address
- pwrite  output  1  APB write
- psel  output  1  APB select
- penable  output  1  APB enable
- pstrb  output  4  APB strobes
- pwdata  output  32  APB write data
- prdata  input  32  APB read data
- pready  input  1  APB ready
- pslverr  input  1  APB slave error

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - All outputs 0, except req_ready=1.
  - A reset mid-transfer drops psel/penable in the same instant; no response is produced.
- FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE. All APB outputs are registered.
- IDLE:
  - req_ready=1.
  - On req_valid, capture addr/write/wdata/strb.
  - Go to SETUP. If req_addr[1:0]!=0, go directly to RESP instead with rsp_err=1, rsp_timeout=0, rsp_rdata=0, and issue no APB transfer.
- SETUP (one cycle): psel=1, penable=0; paddr/pwrite/pwdata/pstrb driven from captured values.
- pstrb rules:
  - pstrb forced to 0 on reads.
  - A write with req_strb=0 is still issued unchanged.
- ACCESS:
  - psel=1, penable=1. Address, control and data held stable until exit.
- ACCESS exit on pready=1:
  - Sample prdata (reads only; writes return 0) and pslverr into rsp_rdata/rsp_err.
  - Deassert psel/penable next cycle; go to RESP.
- Timeout in ACCESS:
  - wait counter width clog2(TIMEOUT_CYCLES+1); cleared on SETUP entry; increments each ACCESS cycle with pready=0.
  - If the counter reaches TIMEOUT_CYCLES, abort: psel/penable=0 next cycle, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
  - pready=1 on the same cycle the limit is reached wins: normal completion.
  - A late pready after abort is ignored.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready. req_ready=0.
  - On handshake go to IDLE; rsp_valid=0 next cycle.
- Latency (zero-wait slave, rsp_ready=1), request accepted at cycle T:
  - SETUP at T+1.
  - ACCESS at T+2 (pready seen).
  - rsp_valid at T+3.
  - Next request may be accepted at T+4.
- Each pready-low ACCESS cycle adds one cycle of latency.
- Idle APB outputs:
  - psel=penable=0.
  - paddr/pwrite/pwdata/pstrb retain their last values; not required to be zero.
- pslverr is sampled only when psel&penable&pready.
- Completing an ACCESS does not require pslverr=0.

Test Plan:
- Aligned write, addr=0x004, wdata=0xA5A5_0F0F, strb=0xF, pready tied 1 -> SETUP at T+1, ACCESS at T+2, rsp_valid at T+3 with rsp_err=0 and rsp_rdata=0. APB signals stable across SETUP/ACCESS.
- Read addr=0x200, pready low 2 cycles then high with prdata=0x1234_5678 -> penable high for 3 cycles, rsp_rdata=0x1234_5678, pstrb=0 throughout, rsp_valid at T+5.
- Write with pslverr=1 on the pready cycle -> rsp_err=1, rsp_timeout=0, psel drops the next cycle.
- Timeout: TIMEOUT_CYCLES=16, pready held 0 -> abort after 16 ACCESS cycles with rsp_err=1 and rsp_timeout=1. A pready pulse afterwards causes no second response. Repeat with TIMEOUT_CYCLES=0 and pready after 100 cycles -> normal completion.
- Misaligned read addr=0x006 -> no psel assertion, rsp_valid at T+1 with rsp_err=1.
- Backpressure and reset:
  - rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready=0, second req_valid not accepted until the response handshake.
  - Assert rst_n=0 mid-ACCESS -> psel/penable/rsp_valid=0 immediately and req_ready=1 after release.
